sram_sp_mask_init_ext: RTL and testbench

- Parametrised single-port synchronous SRAM wrapper; successor to the fixed 128x64 single-port array macro.
- Adds per-lane write mask, a hardware clear of the whole array after reset with a ready flag, a read-valid strobe, held read data and out-of-range address protection.
- Instantiated under cache/array blackbox wrappers that need a clean, known-zero array after reset.

---
 rtl/sram_sp_mask_init_ext.sv | 147 ++++++++++++++
 tb/tb_sram_sp_mask_init_ext.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_mask_init_ext.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_mask_init_ext
// Purpose  : Parametrised single-port synchronous SRAM with per-lane write
//            mask. It clears the whole array in hardware after reset and
//            raises a ready flag when the clear is done. Reads have a valid
//            strobe and the read data is held between reads. Accesses to
//            addresses outside the array are protected.
// Ports    : RW0_clk     - clock; all state changes on the rising edge
//            RW0_rst_n   - asynchronous active-low reset
//            RW0_addr    - word address (ADDR_W)
//            RW0_en      - access enable
//            RW0_wmode   - 1 = write, 0 = read
//            RW0_wdata   - write data (DATA_W)
//            RW0_wmask   - write lane enables (DATA_W/MASK_GRAN)
//            RW0_rdata   - held read data (DATA_W)
//            RW0_rvalid  - one-cycle strobe: rdata updated this cycle
//            RW0_ready   - high once the post-reset clear has finished
// Options  : SRAM_SP_OUTREG_EN - when defined, an extra output register
//            follows the array read and read latency becomes 2.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp_mask_init_ext #(
   parameter int ADDR_W    = 7,
   parameter int DEPTH     = 128,
   parameter int DATA_W    = 64,
   parameter int MASK_GRAN = 8,
   parameter int MASK_W    = DATA_W / MASK_GRAN
) (
   input  logic              RW0_clk,
   input  logic              RW0_rst_n,
   input  logic [ADDR_W-1:0] RW0_addr,
   input  logic              RW0_en,
   input  logic              RW0_wmode,
   input  logic [DATA_W-1:0] RW0_wdata,
   input  logic [MASK_W-1:0] RW0_wmask,
   output logic [DATA_W-1:0] RW0_rdata,
   output logic              RW0_rvalid,
   output logic              RW0_ready
);

   // The clear counter has one extra bit, so DEPTH == 2**ADDR_W is
   // represented exactly and the comparisons below do not wrap.
   localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] c_last  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] c_one   = (ADDR_W + 1)'(1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [ADDR_W:0]    r_cnt;
   logic               r_ready;
   logic               r_rvalid;
   logic [DATA_W-1:0]  r_rdata;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_in_range;
   logic               w_rd_acc;
   logic               w_wr_acc;
   logic [ADDR_W-1:0]  w_init_idx;

   assign w_in_range = ({1'b0, RW0_addr} < c_depth);
   assign w_rd_acc   = RW0_en & ~RW0_wmode & r_ready;
   assign w_wr_acc   = RW0_en &  RW0_wmode & r_ready & w_in_range;
   assign w_init_idx = r_cnt[ADDR_W-1:0];

   // Control FSM and read-side registers. Ready is registered on the same
   // edge that writes the last word, so it rises exactly DEPTH edges after
   // reset is released.
   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         r_state  <= ST_INIT;
         r_cnt    <= '0;
         r_ready  <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + c_one;
               if (r_cnt == c_last) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_rd_acc) begin
                  r_rvalid <= 1'b1;
                  // Out-of-range reads still answer, with zero data.
                  r_rdata  <= w_in_range ? r_mem[RW0_addr] : '0;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // Array storage. It has no reset; the INIT sweep zeroes it instead.
   always_ff @(posedge RW0_clk) begin
      if (r_state == ST_INIT) begin
         r_mem[w_init_idx] <= '0;
      end else if (w_wr_acc) begin
         for (int k = 0; k < MASK_W; k++) begin
            if (RW0_wmask[k]) begin
               r_mem[RW0_addr][k*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[k*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

`ifdef SRAM_SP_OUTREG_EN
   logic              r_rvalid_q;
   logic [DATA_W-1:0] r_rdata_q;

   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         r_rvalid_q <= 1'b0;
         r_rdata_q  <= '0;
      end else begin
         r_rvalid_q <= r_rvalid;
         if (r_rvalid) begin
            r_rdata_q <= r_rdata;
         end
      end
   end

   assign RW0_rdata  = r_rdata_q;
   assign RW0_rvalid = r_rvalid_q;
`else
   assign RW0_rdata  = r_rdata;
   assign RW0_rvalid = r_rvalid;
`endif

   assign RW0_ready = r_ready;

`ifndef SYNTHESIS
   // An unknown enable is a protocol violation once requests are accepted.
   a_en_known: assert property (@(posedge RW0_clk) disable iff (!RW0_rst_n)
                                r_ready |-> !$isunknown(RW0_en));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_mask_init_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_sp_mask_init_ext
// Purpose  : Scoreboard bench for sram_sp_mask_init_ext. Instance A is the
//            default 128-word array. Instance B has DEPTH=100, so addresses
//            100..127 are out of range. Both instances share one stimulus
//            stream. Each read pushes its hand-computed result and due cycle
//            into a per-instance queue. A monitor pops an entry on every
//            rvalid.
// Options  : SRAM_SP_OUTREG_EN selects the expected read latency of 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_sp_mask_init_ext;

`ifdef SRAM_SP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  addr = '0;
   logic        en = 1'b0;
   logic        wmode = 1'b0;
   logic [63:0] wdata = '0;
   logic [7:0]  wmask = '0;

   logic [63:0] rdata_a, rdata_b;
   logic        rvalid_a, rvalid_b, ready_a, ready_b;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_sp_mask_init_ext #(.ADDR_W(7), .DEPTH(128), .DATA_W(64), .MASK_GRAN(8)) u_dut_a (
      .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
      .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
      .RW0_rdata(rdata_a), .RW0_rvalid(rvalid_a), .RW0_ready(ready_a));

   sram_sp_mask_init_ext #(.ADDR_W(7), .DEPTH(100), .DATA_W(64), .MASK_GRAN(8)) u_dut_b (
      .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
      .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
      .RW0_rdata(rdata_b), .RW0_rvalid(rvalid_b), .RW0_ready(ready_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_wr(input logic [6:0] a, input logic [63:0] d, input logic [7:0] m);
      addr = a; en = 1'b1; wmode = 1'b1; wdata = d; wmask = m;
      tick();
   endtask

   task automatic do_rd(input logic [6:0] a, input logic [63:0] exp_a, input logic [63:0] exp_b);
      exp_t e;
      addr = a; en = 1'b1; wmode = 1'b0;
      e.due = cyc + LAT;
      e.data = exp_a; qa.push_back(e);
      e.data = exp_b; qb.push_back(e);
      tick();
   endtask

   // Counts edges after reset release until each ready rises. The enable
   // is dropped at edge 90, before either instance can become ready.
   task automatic wait_ready(output int na, output int nb);
      na = -1; nb = -1;
      for (int i = 1; i <= 200; i++) begin
         if (i == 90) en = 1'b0;
         tick();
         if (na < 0 && ready_a) na = i;
         if (nb < 0 && ready_b) nb = i;
         if (na >= 0 && nb >= 0) break;
      end
   endtask

   // Monitor: every rvalid must match the oldest queued entry, both in data
   // and in the cycle it arrives. Entries past their due cycle count as
   // missing responses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid_a) begin
            if (qa.size() == 0) chk("a_unexpected_rvalid", 64'd1, 64'd0);
            else begin
               chk("a_rdata", rdata_a, qa[0].data);
               chk("a_latency", 64'(cyc), 64'(qa[0].due));
               void'(qa.pop_front());
            end
         end else if (qa.size() != 0 && qa[0].due < cyc) begin
            chk("a_missing_rvalid", 64'd0, 64'd1);
            void'(qa.pop_front());
         end
         if (rvalid_b) begin
            if (qb.size() == 0) chk("b_unexpected_rvalid", 64'd1, 64'd0);
            else begin
               chk("b_rdata", rdata_b, qb[0].data);
               chk("b_latency", 64'(cyc), 64'(qb[0].due));
               void'(qb.pop_front());
            end
         end else if (qb.size() != 0 && qb[0].due < cyc) begin
            chk("b_missing_rvalid", 64'd0, 64'd1);
            void'(qb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int na, nb;
      localparam logic [63:0] V1 = 64'hA1A1_A1A1_0000_0001;
      localparam logic [63:0] V2 = 64'hB2B2_B2B2_0000_0002;
      localparam logic [63:0] V3 = 64'hC3C3_C3C3_0000_0003;

      // Reset state
      repeat (3) tick();
      chk("rst_ready_a", 64'(ready_a), 64'd0);
      chk("rst_rvalid_a", 64'(rvalid_a), 64'd0);
      chk("rst_rdata_a", rdata_a, 64'd0);
      chk("rst_ready_b", 64'(ready_b), 64'd0);

      // Writes held on during INIT must be ignored. Reset is re-asserted
      // 40 cycles into INIT, and the full clear must rerun.
      addr = 7'd0; en = 1'b1; wmode = 1'b1; wdata = '1; wmask = 8'hFF;
      rst_n = 1'b1;
      repeat (40) tick();
      chk("mid_init_ready_a", 64'(ready_a), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ready_a", 64'(ready_a), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      wait_ready(na, nb);
      chk("init_cycles_a", 64'(na), 64'd128);
      chk("init_cycles_b", 64'(nb), 64'd100);

      // Cleared array: instance A is in range at 127, instance B is not.
      do_rd(7'd0,   64'd0, 64'd0);
      do_rd(7'd127, 64'd0, 64'd0);
      idle(3);

      // Masked merge, with a read on the cycle right after the write.
      do_wr(7'd5, 64'h1122334455667788, 8'hFF);
      do_wr(7'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      do_rd(7'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
      idle(2);

      // A zero mask must leave the word unchanged and produce no rvalid.
      do_wr(7'd5, 64'h0, 8'h00);
      do_rd(7'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
      idle(2);

      // Back-to-back reads, then four idle cycles where rdata must hold.
      do_wr(7'd1, V1, 8'hFF);
      do_wr(7'd2, V2, 8'hFF);
      do_wr(7'd3, V3, 8'hFF);
      do_rd(7'd1, V1, V1);
      do_rd(7'd2, V2, V2);
      do_rd(7'd3, V3, V3);
      en = 1'b0;
      repeat (LAT - 1) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_rdata_a", rdata_a, V3);
         chk("hold_rdata_b", rdata_b, V3);
         chk("hold_rvalid_a", 64'(rvalid_a), 64'd0);
      end

      // Out of range for B only: addr 110 is dropped and reads back zero.
      do_wr(7'd110, 64'hDEADBEEF01100110, 8'hFF);
      do_wr(7'd99,  64'h00990099CAFEF00D, 8'hFF);
      do_rd(7'd110, 64'hDEADBEEF01100110, 64'd0);
      do_rd(7'd99,  64'h00990099CAFEF00D, 64'h00990099CAFEF00D);
      do_rd(7'd0,   64'd0, 64'd0);
      idle(4);

      // Reset during RUN: all data is cleared again.
      rst_n = 1'b0;
      #1;
      chk("run_rst_rdata_a", rdata_a, 64'd0);
      chk("run_rst_rdata_b", rdata_b, 64'd0);
      chk("run_rst_ready_b", 64'(ready_b), 64'd0);
      tick();
      rst_n = 1'b1;
      wait_ready(na, nb);
      chk("reinit_cycles_a", 64'(na), 64'd128);
      chk("reinit_cycles_b", 64'(nb), 64'd100);
      do_rd(7'd5,   64'd0, 64'd0);
      do_rd(7'd99,  64'd0, 64'd0);
      do_rd(7'd110, 64'd0, 64'd0);
      do_rd(7'd3,   64'd0, 64'd0);
      idle(5);

      chk("drain_qa", 64'(qa.size()), 64'd0);
      chk("drain_qb", 64'(qb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
